rr_burst_drain: RTL and testbench
=================================

# rr_burst_drain

Round-robin drain stage that sits directly downstream of a bank of per-port register FIFOs in the shared-cache switch. It watches each FIFO's `empty` flag and pops the head word with a single-cycle `rd_en`. Winners are chosen round-robin, and a grant is held for bursts of up to `BURST_LEN` words. Popped words are forwarded through one registered valid/ready output stage, tagged with the source port, at one word per cycle.

## Interface
- `NUM_PORTS`, 4 — number of upstream FIFOs; ≥2.
- `DATA_WIDTH`, 8 — word width; matches the upstream FIFO.
- `BURST_LEN`, 4 — maximum consecutive pops per grant; ≥1.
- `PORT_W`, `$clog2(NUM_PORTS)` — derived, not overridden.
- Reset: one clock; reset is asynchronous and active-high.
- Ports:
  - `clk` input 1 — sole clock, rising edge.
  - `rst` input 1 — asynchronous, active-high reset.
  - `fifo_empty` input `NUM_PORTS` — bit i is the empty flag of FIFO i.
  - `fifo_rd_data` input `NUM_PORTS*DATA_WIDTH` — head word of FIFO i in slice i. It is combinationally valid whenever `fifo_empty[i]`=0.
  - `fifo_rd_en` output `NUM_PORTS` — one-hot-or-zero pop strobe, combinational.
  - `out_valid` output 1 — output register holds a word.
  - `out_data` output `DATA_WIDTH` — forwarded word.
  - `out_port` output `PORT_W` — source FIFO index of `out_data`.
  - `out_first` output 1 — word is the first of a new grant.
  - `out_ready` input 1 — downstream accepts the word when `out_valid & out_ready`.

## Operation
- Slot availability: `slot_free = !out_valid | out_ready`. A pop happens only in a cycle where `slot_free`=1, and at most one `fifo_rd_en` bit is high per cycle.
- States:
  - IDLE: no grant held.
  - LOCKED: grant held on port `g`, with beat counter `beats` (1..`BURST_LEN`).
- Per cycle with `slot_free`=1:
  - LOCKED, `fifo_empty[g]`=0 and `beats`<`BURST_LEN`: pop `g`, `beats`+1, `out_first`=0.
  - Otherwise (IDLE, `g` empty, or `beats`=`BURST_LEN`): release the grant and set `rr_ptr` = (`g`+1) mod `NUM_PORTS` if a grant was held.
    - In the same cycle, pick the first non-empty port scanning from the updated `rr_ptr` upward with wrap.
    - If one is found, pop it, enter LOCKED with `g`=winner, `beats`=1 and `out_first`=1.
    - If none is found, go to IDLE with no pop.
- A burst that ends, or a FIFO that empties, causes no bubble when another port is non-empty.
- When `slot_free`=0:
  - `fifo_rd_en`=0.
  - The output register, state, `g`, `beats` and `rr_ptr` all hold.
- Output register on a pop: load `out_data` from the popped slice and set `out_port`=winner, `out_valid`=1. Otherwise, if `out_ready` is high, clear `out_valid`. `out_data` and `out_port` keep their last value while invalid.
- `BURST_LEN`=1 degenerates to strict per-word round-robin.
- `beats` is sized `$clog2(BURST_LEN+1)` bits and never wraps.
- `rr_ptr` wraps from `NUM_PORTS`-1 to 0.

## Timing
- Reset values (asynchronous):
  - `out_valid`=0, `out_data`=0, `out_port`=0, `out_first`=0.
  - State IDLE, `beats`=0, `rr_ptr`=0.
  - `fifo_rd_en` is forced to 0 while `rst`=1.
- Reset asserted mid-burst discards the held grant and the output word. The first post-reset pick scans from port 0.
- Latency: a FIFO going non-empty in cycle N, with the slot free and the port winning, gives `fifo_rd_en` in cycle N and `out_valid` in N+1.
- Throughput: one word per cycle while `out_ready`=1 and any FIFO is non-empty.
- `fifo_rd_en` depends only on registered state, `fifo_empty` and `out_ready`. It has no combinational path from `fifo_rd_data`.

## Structure
- Shared package holds:
  - the state enum (IDLE, LOCKED);
  - the `PORT_W` width function, and a helper function for the beat-counter width.
- Sub-module `rr_pick`: combinational priority picker.
  - Inputs: request vector and start pointer.
  - Outputs: one-hot grant, grant index and `any` flag.
  - Instantiated once.

## Test plan
1. Reset mid-burst: port 1 holds 3 of 6 words remaining, then `rst` pulses → `out_valid`=0 and `fifo_rd_en`=0 during reset. With ports 0 and 1 non-empty afterwards, the first pop goes to port 0.
2. `BURST_LEN`=4, port 1 holds 6 words, others empty, `out_ready`=1 → six consecutive words from `out_port`=1 with no bubble. `out_first`=1 on words 1 and 5 only.
3. `BURST_LEN`=4, each port holds 2 words → output order p0,p0,p1,p1,p2,p2,p3,p3 over 8 consecutive cycles. `out_first` is high on each port change.
4. Backpressure: `out_ready`=0 for 3 cycles mid-burst → `fifo_rd_en`=0 and `out_data`/`out_port` stable. After release, the sequence is complete with no loss or duplication.
5. Fairness: ports 0 and 2 always non-empty, `BURST_LEN`=2 → order 0,0,2,2,0,0,2,2. Ports 1 and 3 are never granted.
6. `BURST_LEN`=1, all four ports always non-empty → order 0,1,2,3,0,1,… with `out_first`=1 on every word.

Source files
------------

// File: rtl/rr_burst_drain_pkg.sv
// rtl/rr_burst_drain_pkg.sv - shared types and width helpers for the round-robin drain stage
package rr_burst_drain_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   function automatic int port_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Counter must represent BURST_LEN itself, hence the +1.
   function automatic int beat_w(input int b);
      return (b > 0) ? $clog2(b + 1) : 1;
   endfunction

endpackage

// File: rtl/rr_burst_drain_rr_pick.sv
// rtl/rr_burst_drain_rr_pick.sv - combinational rotating priority picker
// Finds the first set request bit scanning upward from start, wrapping at N.
module rr_pick #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] start,
   output logic [N-1:0] gnt,
   output logic [W-1:0] idx,
   output logic         any
);

   always_comb begin
      int         c;
      logic [W-1:0] ci;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      c   = 0;
      ci  = '0;
      for (int i = 0; i < N; i++) begin
         c = int'(start) + i;
         if (c >= N) begin
            c = c - N;
         end
         ci = W'(c);
         if (!any && req[ci]) begin
            any     = 1'b1;
            idx     = ci;
            gnt[ci] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_burst_drain.sv
// rtl/rr_burst_drain.sv - round-robin burst drain of per-port FIFOs into one registered output
// Grants are held for up to BURST_LEN pops; re-arbitration happens in the same cycle a burst ends.
module rr_burst_drain
   import rr_burst_drain_pkg::*;
#(
   parameter int   NUM_PORTS  = 4,
   parameter int   DATA_WIDTH = 8,
   parameter int   BURST_LEN  = 4,
   localparam int  PORT_W     = port_w(NUM_PORTS)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_PORTS-1:0]            fifo_empty,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] fifo_rd_data,
   output logic [NUM_PORTS-1:0]            fifo_rd_en,
   output logic                            out_valid,
   output logic [DATA_WIDTH-1:0]           out_data,
   output logic [PORT_W-1:0]               out_port,
   output logic                            out_first,
   input  logic                            out_ready
);

   localparam int                 BEAT_W    = beat_w(BURST_LEN);
   localparam logic [BEAT_W-1:0]  BEAT_MAX  = BEAT_W'(BURST_LEN);
   localparam logic [PORT_W-1:0]  LAST_PORT = PORT_W'(NUM_PORTS - 1);

   state_t                state_q, state_d;
   logic [PORT_W-1:0]     g_q, g_d;
   logic [BEAT_W-1:0]     beats_q, beats_d;
   logic [PORT_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic [PORT_W-1:0]     out_port_q, out_port_d;
   logic                  out_first_q, out_first_d;

   logic [DATA_WIDTH-1:0] slice [NUM_PORTS];
   logic                  slot_free;
   logic                  keep_burst;
   logic [PORT_W-1:0]     scan_ptr;
   logic [NUM_PORTS-1:0]  pick_gnt;
   logic [PORT_W-1:0]     pick_idx;
   logic                  pick_any;
   logic [NUM_PORTS-1:0]  rd_en_c;
   logic                  pop;
   logic [PORT_W-1:0]     pop_idx;
   logic                  first_c;

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_slice
      assign slice[i] = fifo_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
   end

   assign slot_free  = !out_valid_q || out_ready;
   assign keep_burst = (state_q == ST_LOCKED) && !fifo_empty[g_q] && (beats_q < BEAT_MAX);
   // Releasing a grant advances the pointer past the holder before the same-cycle rescan.
   assign scan_ptr   = (state_q == ST_LOCKED) ? ((g_q == LAST_PORT) ? '0 : g_q + PORT_W'(1))
                                              : rr_ptr_q;

   rr_pick #(
      .N (NUM_PORTS),
      .W (PORT_W)
   ) u_pick (
      .req   (~fifo_empty),
      .start (scan_ptr),
      .gnt   (pick_gnt),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   always_comb begin
      state_d     = state_q;
      g_d         = g_q;
      beats_d     = beats_q;
      rr_ptr_d    = rr_ptr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_port_d  = out_port_q;
      out_first_d = out_first_q;
      rd_en_c     = '0;
      pop         = 1'b0;
      pop_idx     = g_q;
      first_c     = 1'b0;

      if (slot_free) begin
         if (keep_burst) begin
            pop          = 1'b1;
            pop_idx      = g_q;
            beats_d      = beats_q + BEAT_W'(1);
            rd_en_c[g_q] = 1'b1;
         end else begin
            rr_ptr_d = scan_ptr;
            if (pick_any) begin
               pop     = 1'b1;
               pop_idx = pick_idx;
               first_c = 1'b1;
               rd_en_c = pick_gnt;
               state_d = ST_LOCKED;
               g_d     = pick_idx;
               beats_d = BEAT_W'(1);
            end else begin
               state_d = ST_IDLE;
               beats_d = '0;
            end
         end
      end

      if (pop) begin
         out_valid_d = 1'b1;
         out_data_d  = slice[pop_idx];
         out_port_d  = pop_idx;
         out_first_d = first_c;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         g_q         <= '0;
         beats_q     <= '0;
         rr_ptr_q    <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_port_q  <= '0;
         out_first_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         g_q         <= g_d;
         beats_q     <= beats_d;
         rr_ptr_q    <= rr_ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_port_q  <= out_port_d;
         out_first_q <= out_first_d;
      end
   end

   assign fifo_rd_en = rst ? '0 : rd_en_c;
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_port   = out_port_q;
   assign out_first  = out_first_q;

endmodule

// File: tb/tb_rr_burst_drain.sv
// tb/tb_rr_burst_drain.sv - directed self-checking bench for rr_burst_drain
// Main instance (BURST_LEN=4) drains a FIFO model; two fixed-request instances cover BURST_LEN 2 and 1.
module tb_rr_burst_drain;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        out_ready = 1'b1;
   logic [3:0]  fifo_empty;
   logic [31:0] fifo_rd_data;
   logic [3:0]  fifo_rd_en;
   logic        out_valid;
   logic [7:0]  out_data;
   logic [1:0]  out_port;
   logic        out_first;

   logic [3:0]  b2_empty = 4'b1010;
   logic [3:0]  b1_empty = 4'b0000;
   logic [31:0] const_data = 32'h3322_1100;
   logic        const_ready = 1'b1;
   logic [3:0]  b2_rd_en, b1_rd_en;
   logic        b2_valid, b1_valid, b2_first, b1_first;
   logic [7:0]  b2_data, b1_data;
   logic [1:0]  b2_port, b1_port;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rr_burst_drain #(.NUM_PORTS(4), .DATA_WIDTH(8), .BURST_LEN(4)) u_dut (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
      .fifo_rd_en(fifo_rd_en), .out_valid(out_valid), .out_data(out_data),
      .out_port(out_port), .out_first(out_first), .out_ready(out_ready));

   rr_burst_drain #(.NUM_PORTS(4), .DATA_WIDTH(8), .BURST_LEN(2)) u_bl2 (
      .clk(clk), .rst(rst), .fifo_empty(b2_empty), .fifo_rd_data(const_data),
      .fifo_rd_en(b2_rd_en), .out_valid(b2_valid), .out_data(b2_data),
      .out_port(b2_port), .out_first(b2_first), .out_ready(const_ready));

   rr_burst_drain #(.NUM_PORTS(4), .DATA_WIDTH(8), .BURST_LEN(1)) u_bl1 (
      .clk(clk), .rst(rst), .fifo_empty(b1_empty), .fifo_rd_data(const_data),
      .fifo_rd_en(b1_rd_en), .out_valid(b1_valid), .out_data(b1_data),
      .out_port(b1_port), .out_first(b1_first), .out_ready(const_ready));

   // FIFO model: tasks append (wr_cnt), the clocked process pops (rd_cnt).
   logic [7:0] mem [4][32];
   int wr_cnt [4];
   int rd_cnt [4];
   int underflow = 0;
   int multi_pop = 0;

   initial begin
      for (int i = 0; i < 4; i++) begin
         wr_cnt[i] = 0;
         rd_cnt[i] = 0;
         for (int k = 0; k < 32; k++) mem[i][k] = 8'h00;
      end
   end

   always_comb begin
      fifo_empty   = '0;
      fifo_rd_data = '0;
      for (int i = 0; i < 4; i++) begin
         fifo_empty[i]          = (wr_cnt[i] == rd_cnt[i]);
         fifo_rd_data[i*8 +: 8] = mem[i][rd_cnt[i][4:0]];
      end
   end

   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (fifo_rd_en[i]) begin
            if (wr_cnt[i] == rd_cnt[i]) underflow <= underflow + 1;
            else rd_cnt[i] <= rd_cnt[i] + 1;
         end
      end
      if ($countones(fifo_rd_en) > 1 || $countones(b2_rd_en) > 1 || $countones(b1_rd_en) > 1)
         multi_pop <= multi_pop + 1;
   end

   logic [7:0] cap_data  [16];
   logic [1:0] cap_port  [16];
   logic       cap_first [16];
   int         cap_cyc   [16];
   int         cap_n;

   task automatic load(input int p, input int n, input logic [7:0] base);
      for (int k = 0; k < n; k++) begin
         mem[p][wr_cnt[p][4:0]] = 8'(base + 8'(k));
         wr_cnt[p] = wr_cnt[p] + 1;
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (fifo_empty == 4'hF && !out_valid) break;
      end
   endtask

   // Records accepted words from instance sel (0 main, 1 BURST_LEN=2, 2 BURST_LEN=1).
   task automatic capture(input int sel, input int ncyc);
      cap_n = 0;
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         #1;
         if (cap_n < 16) begin
            if (sel == 0 && out_valid && out_ready) begin
               cap_data[cap_n] = out_data; cap_port[cap_n] = out_port;
               cap_first[cap_n] = out_first; cap_cyc[cap_n] = c; cap_n++;
            end else if (sel == 1 && b2_valid) begin
               cap_data[cap_n] = b2_data; cap_port[cap_n] = b2_port;
               cap_first[cap_n] = b2_first; cap_cyc[cap_n] = c; cap_n++;
            end else if (sel == 2 && b1_valid) begin
               cap_data[cap_n] = b1_data; cap_port[cap_n] = b1_port;
               cap_first[cap_n] = b1_first; cap_cyc[cap_n] = c; cap_n++;
            end
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      load(3, 1, 8'h3A);
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_port !== 2'd0 || out_first !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs got v=%b d=%h p=%0d f=%b want 0/00/0/0", out_valid, out_data, out_port, out_first);
      end
      checks++;
      if (fifo_rd_en !== 4'b0000) begin
         errors++;
         $display("FAIL reset_rd_en got %b want 0000", fifo_rd_en);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (fifo_rd_en !== 4'b1000) begin
         errors++;
         $display("FAIL post_reset_latency got %b want 1000", fifo_rd_en);
      end
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h3A || out_port !== 2'd3 || out_first !== 1'b1) begin
         errors++;
         $display("FAIL first_word got v=%b d=%h p=%0d f=%b want 1/3a/3/1", out_valid, out_data, out_port, out_first);
      end
      drain();
   endtask

   task automatic test_reset_mid_burst();
      apply_reset();
      load(1, 6, 8'h10);
      repeat (3) @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h12 || out_port !== 2'd1) begin
         errors++;
         $display("FAIL mid_burst_pre got v=%b d=%h p=%0d want 1/12/1", out_valid, out_data, out_port);
      end
      load(0, 2, 8'h05);
      rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || fifo_rd_en !== 4'b0000) begin
         errors++;
         $display("FAIL mid_burst_reset got v=%b d=%h rd=%b want 0/00/0000", out_valid, out_data, fifo_rd_en);
      end
      @(negedge clk);
      checks++;
      if (fifo_rd_en !== 4'b0000 || rd_cnt[1] !== 3) begin
         errors++;
         $display("FAIL reset_hold got rd=%b pops=%0d want 0000/3", fifo_rd_en, rd_cnt[1]);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (fifo_rd_en !== 4'b0001) begin
         errors++;
         $display("FAIL post_reset_pick got %b want 0001", fifo_rd_en);
      end
      @(negedge clk);
      #1;
      checks++;
      if (out_port !== 2'd0 || out_data !== 8'h05 || out_first !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_word got p=%0d d=%h f=%b want 0/05/1", out_port, out_data, out_first);
      end
      drain();
   endtask

   task automatic test_single_port_burst();
      apply_reset();
      load(1, 6, 8'h40);
      capture(0, 10);
      checks++;
      if (cap_n !== 6) begin
         errors++;
         $display("FAIL burst_count got %0d want 6", cap_n);
      end
      for (int k = 0; k < 6 && k < cap_n; k++) begin
         checks++;
         if (cap_data[k] !== 8'(8'h40 + k) || cap_port[k] !== 2'd1 || cap_cyc[k] !== k + 1 ||
             cap_first[k] !== (k == 0 || k == 4)) begin
            errors++;
            $display("FAIL burst_word%0d got d=%h p=%0d f=%b cyc=%0d want d=%h p=1 f=%b cyc=%0d",
                     k, cap_data[k], cap_port[k], cap_first[k], cap_cyc[k], 8'(8'h40 + k), (k == 0 || k == 4), k + 1);
         end
      end
      drain();
   endtask

   task automatic test_round_robin();
      apply_reset();
      for (int p = 0; p < 4; p++) load(p, 2, 8'(8'h50 + 16 * p));
      capture(0, 12);
      checks++;
      if (cap_n !== 8) begin
         errors++;
         $display("FAIL rr_count got %0d want 8", cap_n);
      end
      for (int k = 0; k < 8 && k < cap_n; k++) begin
         checks++;
         if (cap_port[k] !== 2'(k / 2) || cap_data[k] !== 8'(8'h50 + 16 * (k / 2) + (k % 2)) ||
             cap_first[k] !== (k % 2 == 0) || cap_cyc[k] !== k + 1) begin
            errors++;
            $display("FAIL rr_word%0d got p=%0d d=%h f=%b cyc=%0d want p=%0d d=%h f=%b cyc=%0d",
                     k, cap_port[k], cap_data[k], cap_first[k], cap_cyc[k],
                     k / 2, 8'(8'h50 + 16 * (k / 2) + (k % 2)), (k % 2 == 0), k + 1);
         end
      end
      drain();
   endtask

   task automatic test_backpressure();
      apply_reset();
      load(2, 6, 8'h60);
      cap_n = 0;
      for (int c = 0; c < 14; c++) begin
         if (c > 0) @(negedge clk);
         out_ready = !(c >= 2 && c <= 4);
         #1;
         if (!out_ready) begin
            checks++;
            if (fifo_rd_en !== 4'b0000 || out_valid !== 1'b1 || out_data !== 8'h61 || out_port !== 2'd2) begin
               errors++;
               $display("FAIL stall_c%0d got rd=%b v=%b d=%h p=%0d want 0000/1/61/2",
                        c, fifo_rd_en, out_valid, out_data, out_port);
            end
         end
         if (out_valid && out_ready && cap_n < 16) begin
            cap_data[cap_n] = out_data; cap_port[cap_n] = out_port;
            cap_first[cap_n] = out_first; cap_n++;
         end
      end
      out_ready = 1'b1;
      checks++;
      if (cap_n !== 6) begin
         errors++;
         $display("FAIL bp_count got %0d want 6", cap_n);
      end
      for (int k = 0; k < 6 && k < cap_n; k++) begin
         checks++;
         if (cap_data[k] !== 8'(8'h60 + k) || cap_port[k] !== 2'd2 || cap_first[k] !== (k == 0 || k == 4)) begin
            errors++;
            $display("FAIL bp_word%0d got d=%h p=%0d f=%b want d=%h p=2 f=%b",
                     k, cap_data[k], cap_port[k], cap_first[k], 8'(8'h60 + k), (k == 0 || k == 4));
         end
      end
      drain();
   endtask

   task automatic test_fairness();
      apply_reset();
      capture(1, 8);
      checks++;
      if (cap_n !== 8) begin
         errors++;
         $display("FAIL fair_count got %0d want 8", cap_n);
      end
      for (int k = 0; k < 8 && k < cap_n; k++) begin
         checks++;
         if (cap_port[k] !== ((k % 4) < 2 ? 2'd0 : 2'd2) || cap_first[k] !== (k % 2 == 0) ||
             cap_data[k] !== ((k % 4) < 2 ? 8'h00 : 8'h22)) begin
            errors++;
            $display("FAIL fair_word%0d got p=%0d f=%b d=%h want p=%0d f=%b",
                     k, cap_port[k], cap_first[k], cap_data[k], (k % 4) < 2 ? 0 : 2, (k % 2 == 0));
         end
      end
   endtask

   task automatic test_strict_rr();
      apply_reset();
      capture(2, 8);
      checks++;
      if (cap_n !== 8) begin
         errors++;
         $display("FAIL strict_count got %0d want 8", cap_n);
      end
      for (int k = 0; k < 8 && k < cap_n; k++) begin
         checks++;
         if (cap_port[k] !== 2'(k % 4) || cap_first[k] !== 1'b1 || cap_data[k] !== 8'(8'h11 * (k % 4))) begin
            errors++;
            $display("FAIL strict_word%0d got p=%0d f=%b d=%h want p=%0d f=1 d=%h",
                     k, cap_port[k], cap_first[k], cap_data[k], k % 4, 8'(8'h11 * (k % 4)));
         end
      end
   endtask

   task automatic test_pop_sanity();
      checks++;
      if (underflow !== 0 || multi_pop !== 0) begin
         errors++;
         $display("FAIL pop_sanity got underflow=%0d multi=%0d want 0/0", underflow, multi_pop);
      end
   endtask

   initial begin
      test_reset();
      test_reset_mid_burst();
      test_single_port_burst();
      test_round_robin();
      test_backpressure();
      test_fairness();
      test_strict_rr();
      test_pop_sanity();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
